// File: rtl/piso_param.sv
// Parallel-in serial-out shifter: captures a WIDTH-bit word and emits it one bit per clock.
// Optional build macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [FRAME-1:0] frame_w;
  logic [FRAME-1:0] shifted_w;
  logic             head_w;
  logic             accept;

  // The frame is laid out so the first bit to emit sits at the shift head and
  // the parity bit (when present) is always reached last.
  generate
    if (MSB_FIRST) begin : g_msb
`ifdef PISO_PARITY_EN
      assign frame_w = {in, ^in};
`else
      assign frame_w = in;
`endif
      assign shifted_w = {sr_q[FRAME-2:0], 1'b0};
      assign head_w    = sr_q[FRAME-1];
    end else begin : g_lsb
`ifdef PISO_PARITY_EN
      assign frame_w = {^in, in};
`else
      assign frame_w = in;
`endif
      assign shifted_w = {1'b0, sr_q[FRAME-1:1]};
      assign head_w    = sr_q[0];
    end
  endgenerate

  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = busy;
  assign last      = busy && (cnt_q == LAST_IDX);
  assign in_ready  = !busy || last;
  assign out       = busy && head_w;
  assign accept    = load && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sr_d    = frame_w;
    end else if (busy) begin
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sr_d  = shifted_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_piso_param.sv
// Bench for piso_param: three instances (8-bit MSB-first, 4-bit LSB-first, 4-bit MSB-first),
// directed frames plus a randomized run against a bit-queue reference model.
module tb_piso_param;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       rst;
  logic       load0, load1, load2;
  logic [7:0] in0;
  logic [3:0] in1, in2;
  logic [2:0] rdy, so, vld, lst, bsy;

  int total = 0;
  int bad   = 0;

  piso_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .load(load0), .in(in0), .in_ready(rdy[0]),
    .out(so[0]), .out_valid(vld[0]), .last(lst[0]), .busy(bsy[0]));
  piso_param #(.WIDTH(4), .MSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .load(load1), .in(in1), .in_ready(rdy[1]),
    .out(so[1]), .out_valid(vld[1]), .last(lst[1]), .busy(bsy[1]));
  piso_param #(.WIDTH(4), .MSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .load(load2), .in(in2), .in_ready(rdy[2]),
    .out(so[2]), .out_valid(vld[2]), .last(lst[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int idx);
    return (idx == 0) ? 8 : 4;
  endfunction

  // Observation vector: {in_ready, out, out_valid, last, busy}
  function automatic logic [4:0] obs(input int idx);
    return {rdy[idx], so[idx], vld[idx], lst[idx], bsy[idx]};
  endfunction

  task automatic set_in(input int idx, input logic ld, input logic [7:0] w);
    case (idx)
      0:       begin load0 = ld; in0 = w;      end
      1:       begin load1 = ld; in1 = w[3:0]; end
      default: begin load2 = ld; in2 = w[3:0]; end
    endcase
  endtask

  task automatic test_reset();
    logic [4:0] o;
    #2;
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      total++;
      if (o !== 5'b10000) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%b want=%b", i, o, 5'b10000);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Two words on the 4-bit MSB-first instance: 1001 then 1011
  task automatic test_msb4();
    bit exp[$];
    logic [4:0] o, e;
    logic [7:0] words [2];
    int fr;
    fr = 4 + PAR;
    words[0] = 8'h09;
    words[1] = 8'h0B;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) exp = '{1, 0, 0, 1};
      else        exp = '{1, 0, 1, 1};
      if (PAR == 1) exp.push_back(n == 1);
      @(negedge clk);
      set_in(2, 1'b1, words[n]);
      for (int k = 0; k < fr; k++) begin
        @(negedge clk);
        set_in(2, 1'b0, 8'($urandom));
        o = obs(2);
        e = {(k == fr - 1), exp[k], 1'b1, (k == fr - 1), 1'b1};
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL msb4 word%0d bit%0d got=%b want=%b", n, k, o, e);
        end
      end
      @(negedge clk);
      o = obs(2);
      total++;
      if (o !== 5'b10000) begin
        bad++;
        $display("FAIL msb4_idle word%0d got=%b want=%b", n, o, 5'b10000);
      end
    end
  endtask

  task automatic test_lsb4();
    bit exp[$];
    logic [4:0] o, e;
    int fr, busy_cycles;
    fr = 4 + PAR;
    exp = '{1, 0, 1, 1};
    if (PAR == 1) exp.push_back(1);
    busy_cycles = 0;
    @(negedge clk);
    set_in(1, 1'b1, 8'h0D);
    for (int k = 0; k < fr + 2; k++) begin
      @(negedge clk);
      set_in(1, 1'b0, 8'($urandom));
      o = obs(1);
      if (o[0]) busy_cycles++;
      if (k < fr) e = {(k == fr - 1), exp[k], 1'b1, (k == fr - 1), 1'b1};
      else        e = 5'b10000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lsb4 cycle%0d got=%b want=%b", k, o, e);
      end
    end
    total++;
    if (busy_cycles != fr) begin
      bad++;
      $display("FAIL lsb4_busy_len got=%0d want=%0d", busy_cycles, fr);
    end
  endtask

  task automatic test_back_to_back();
    bit exp[$];
    logic [4:0] o, e;
    logic lk;
    int fr;
    fr = 4 + PAR;
    exp = '{1, 0, 1, 0};
    if (PAR == 1) exp.push_back(0);
    exp.push_back(0); exp.push_back(1); exp.push_back(1); exp.push_back(0);
    if (PAR == 1) exp.push_back(0);
    @(negedge clk);
    set_in(2, 1'b1, 8'h0A);
    for (int k = 0; k < 2 * fr; k++) begin
      @(negedge clk);
      if (k == fr - 1) set_in(2, 1'b1, 8'h06);
      else             set_in(2, 1'b0, 8'($urandom));
      o = obs(2);
      lk = ((k % fr) == fr - 1);
      e = {lk, exp[k], 1'b1, lk, 1'b1};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back bit%0d got=%b want=%b", k, o, e);
      end
    end
    @(negedge clk);
    o = obs(2);
    total++;
    if (o !== 5'b10000) begin
      bad++;
      $display("FAIL back_to_back_idle got=%b want=%b", o, 5'b10000);
    end
  endtask

  task automatic test_ignore_load();
    bit exp[$];
    logic [4:0] o, e;
    int fr;
    fr = 8 + PAR;
    exp = '{1, 0, 1, 0, 0, 1, 0, 1};
    if (PAR == 1) exp.push_back(0);
    @(negedge clk);
    set_in(0, 1'b1, 8'hA5);
    for (int k = 0; k < fr + 1; k++) begin
      @(negedge clk);
      if (k == 3) set_in(0, 1'b1, 8'hFF);
      else        set_in(0, 1'b0, 8'($urandom));
      o = obs(0);
      if (k < fr) e = {(k == fr - 1), exp[k], 1'b1, (k == fr - 1), 1'b1};
      else        e = 5'b10000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ignore_load cycle%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    bit exp[$];
    logic [4:0] o, e;
    int fr;
    fr = 8 + PAR;
    exp = '{1, 1, 0, 0, 0};
    @(negedge clk);
    set_in(0, 1'b1, 8'hC3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(0, 1'b0, 8'h00);
      o = obs(0);
      e = {1'b0, exp[k], 1'b1, 1'b0, 1'b1};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort_pre bit%0d got=%b want=%b", k, o, e);
      end
    end
    #1 rst = 1'b0;
    #1;
    o = obs(0);
    total++;
    if (o !== 5'b10000) begin
      bad++;
      $display("FAIL abort_immediate got=%b want=%b", o, 5'b10000);
    end
    @(negedge clk);
    o = obs(0);
    total++;
    if (o !== 5'b10000) begin
      bad++;
      $display("FAIL abort_held got=%b want=%b", o, 5'b10000);
    end
    rst = 1'b1;
    exp = '{1, 0, 0, 0, 0, 0, 0, 1};
    if (PAR == 1) exp.push_back(0);
    set_in(0, 1'b1, 8'h81);
    for (int k = 0; k < fr + 1; k++) begin
      @(negedge clk);
      set_in(0, 1'b0, 8'($urandom));
      o = obs(0);
      if (k < fr) e = {(k == fr - 1), exp[k], 1'b1, (k == fr - 1), 1'b1};
      else        e = 5'b10000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL after_abort cycle%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  // Reference: a queue of the bits still to be emitted; the head is the current bit.
  task automatic test_random(input int idx, input int ncyc);
    bit q[$];
    logic [4:0] o, e;
    logic [7:0] wd, mask;
    logic ld, acc, b;
    int w, fr;
    w    = wid(idx);
    fr   = w + PAR;
    mask = (w == 8) ? 8'hFF : 8'h0F;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      o = obs(idx);
      if (q.size() > 0) e = {(q.size() == 1), q[0], 1'b1, (q.size() == 1), 1'b1};
      else              e = 5'b10000;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random dut%0d cycle%0d got=%b want=%b", idx, c, o, e);
      end
      ld = (c < ncyc - 2 * fr) && ($urandom_range(0, 9) < 4);
      wd = 8'($urandom) & mask;
      set_in(idx, ld, wd);
      acc = ld && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < fr; i++) begin
          if (i == w)          b = ^wd;
          else if (idx == 1)   b = wd[i];
          else                 b = wd[w - 1 - i];
          q.push_back(b);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    test_reset();
    test_msb4();
    test_lsb4();
    test_back_to_back();
    test_ignore_load();
    test_async_reset();
    test_random(0, 300);
    test_random(1, 200);
    test_random(2, 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_param.md
PISO_PARAM -- requirements
Module: piso_param

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word (legal range 2..64).
REQ-002 Parameter: MSB_FIRST, default 1; 1 shifts in[WIDTH-1] first, 0 shifts in[0] first.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is released synchronously to clk by the surrounding system.
REQ-005 Port: load  input  1  request to capture a parallel word.
REQ-006 Port: in  input  WIDTH  parallel data word.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: out  output  1  serial data bit.
REQ-009 Port: out_valid  output  1  out carries a frame bit this cycle.
REQ-010 Port: last  output  1  out carries the final bit of the current frame.
REQ-011 Port: busy  output  1  a frame is in progress.

Function
REQ-012 FRAME is WIDTH bits, or WIDTH+1 when PARITY_EN is defined.
REQ-013 Two states: IDLE and SHIFT; a bit counter of ceil(log2(FRAME+1)) bits tracks the bit index.
REQ-014 A word is accepted on a rising edge where load=1 and in_ready=1; in is captured into the shift register on that edge.
REQ-015 in_ready = 1 in IDLE, and in SHIFT only while last=1; otherwise 0.
REQ-016 Latency: the first frame bit appears on out in the cycle immediately after the accepting edge; each subsequent edge advances exactly one bit.
REQ-017 out_valid = busy = 1 for exactly FRAME consecutive cycles per accepted word.
REQ-018 last = 1 only in the cycle where bit index = FRAME-1.
REQ-019 At the edge ending the last bit: without acceptance, go to IDLE; with acceptance (load=1), start the new frame with no idle gap.
REQ-020 load=1 in SHIFT while last=0 is ignored; in is not sampled and the frame continues unaffected.
REQ-021 In IDLE, out=0, out_valid=0, last=0, busy=0.
REQ-022 Changes on in after the accepting edge do not affect the frame in progress.

Reset
REQ-023 While rst=0: state=IDLE, counter=0, shift register=0, out=0, out_valid=0, last=0, busy=0, in_ready=1.
REQ-024 Reset asserted mid-frame aborts the frame with no further bits emitted; the first acceptance after release starts a fresh frame at bit 0.

Configuration
REQ-025 Macro PISO_PARITY_EN: when defined, an even-parity bit (XOR of all WIDTH captured bits) is appended as frame bit WIDTH, after all data bits regardless of MSB_FIRST, and last marks that parity bit.
REQ-026 When PISO_PARITY_EN is not defined, no parity logic is present, FRAME=WIDTH, and last marks the final data bit.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1, rst low 10 ns then high, load=1 with in=4'b1001 for one edge -> out sequence 1,0,0,1 with out_valid=1 for 4 cycles and last=1 on 4th; then IDLE, out=0.
REQ-028 WIDTH=4, MSB_FIRST=0, in=4'b1101 accepted -> out 1,0,1,1; busy high exactly 4 cycles.
REQ-029 WIDTH=4, MSB_FIRST=1, in=4'b1010 accepted, then load=1 with in=4'b0110 held during last -> out 1,0,1,0,0,1,1,0 contiguous, out_valid never drops, last high on cycles 4 and 8.
REQ-030 WIDTH=8, in=8'hA5 accepted, load=1 with in=8'hFF on bit index 3 -> ignored; out=1,0,1,0,0,1,0,1 and in_ready=0 on bit indices 0..6.
REQ-031 WIDTH=8, in=8'hC3 accepted, rst=0 asynchronously at bit index 4 -> out, out_valid, busy drop to 0 immediately without waiting for clk; after release, in=8'h81 accepted -> 1,0,0,0,0,0,0,1.
REQ-032 PISO_PARITY_EN defined, WIDTH=4, MSB_FIRST=1, in=4'b1011 -> out 1,0,1,1,1 over 5 cycles, last on 5th; in=4'b1001 -> parity bit 0.
